// File: rtl/ins_pkg.sv
// Shared constants and FSM state type for the instruction RAM and fetch sequencer.
package ins_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] HALT_WORD = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        PRESENT,
        HALT
    } fetch_state_t;
endpackage

// File: rtl/ins_ram_fetch_if.sv
// Loader write bus plus decoder-facing fetch handshake, bundled as one interface.
interface ins_ram_fetch_if;
    import ins_pkg::*;

    logic              RamSelect;
    logic [ADDR_W-1:0] LoadAddr;
    logic [DATA_W-1:0] LoadData;
    logic              Start;
    logic              Ready;
    logic [DATA_W-1:0] Instr;
    logic              Valid;
    logic [ADDR_W-1:0] Pc;
    logic              Halted;
    logic              Busy;

    modport master (
        output RamSelect, LoadAddr, LoadData, Start, Ready,
        input  Instr, Valid, Pc, Halted, Busy
    );

    modport slave (
        input  RamSelect, LoadAddr, LoadData, Start, Ready,
        output Instr, Valid, Pc, Halted, Busy
    );
endinterface

// File: rtl/ins_ram_32x8.sv
// Simple dual-port RAM: synchronous write, registered read. Array contents survive reset.
module ins_ram_32x8 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge Clock) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Only the read register is reset, so the presented word clears while the program stays.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ins_ram_fetch.sv
// Instruction memory fed by the loader, plus a sequencer that streams words to the
// decoder over valid/ready until the halt word is consumed.
module ins_ram_fetch
    import ins_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    ins_ram_fetch_if.slave bus
);
    fetch_state_t      state_q, state_d;
    logic              sel_d1_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;
    logic              we, re;
    logic [DATA_W-1:0] rd_data;

    // The loader presents one last pair on the edge after RamSelect falls.
    assign we = bus.RamSelect | sel_d1_q;

    ins_ram_32x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .we_i    (we),
        .waddr_i (bus.LoadAddr),
        .wdata_i (bus.LoadData),
        .re_i    (re),
        .raddr_i (pc_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            sel_d1_q <= 1'b0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_d1_q <= bus.RamSelect;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        re       = 1'b0;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.RamSelect) begin
                    state_d = LOAD;
                end else if (bus.Start) begin
                    state_d  = FETCH;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            LOAD: begin
                halted_d = 1'b0;
                valid_d  = 1'b0;
                if (!bus.RamSelect && !sel_d1_q) state_d = IDLE;
            end
            FETCH: begin
                if (bus.RamSelect) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                    pc_d    = '0;
                end else begin
                    re      = 1'b1;
                    state_d = PRESENT;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (bus.RamSelect) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                    pc_d    = '0;
                end else if (valid_q && bus.Ready) begin
                    valid_d = 1'b0;
                    if (rd_data == HALT_WORD) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == PRESENT);
    end

    assign bus.Instr  = rd_data;
    assign bus.Valid  = valid_q;
    assign bus.Pc     = pc_q;
    assign bus.Halted = halted_q;
    assign bus.Busy   = busy_q;
endmodule

// File: doc/ins_ram_fetch.md
# ins_ram_fetch

Instruction memory plus fetch sequencer, directly downstream of the instruction loader. While `RamSelect` is high it captures the loader's registered address/data pairs into a 32×8 RAM. On `Start` it fetches words sequentially from address 0 and presents each one to the decoder on a valid/ready handshake. It stops after delivering the halt word `8'hFF`.

## Interface
Parameters:
- `ADDR_W`, 5: address width.
- `DATA_W`, 8: instruction width.
- `DEPTH`, 32: number of words (`2**ADDR_W`).
- `HALT_WORD`, `8'hFF`: terminator opcode.

Ports:
- `Clock`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `RamSelect`  in  1  load mode request from the loader.
- `LoadAddr`  in  `ADDR_W`  loader write address.
- `LoadData`  in  `DATA_W`  loader write data.
- `Start`  in  1  begin fetching at address 0 (single-cycle pulse or level).
- `Ready`  in  1  decoder accepts `Instr` this cycle.
- `Instr`  out  `DATA_W`  fetched instruction.
- `Valid`  out  1  `Instr` is valid.
- `Pc`  out  `ADDR_W`  address of the word currently being fetched or presented.
- `Halted`  out  1  halt word was consumed.
- `Busy`  out  1  high in FETCH or PRESENT.

## Operation
- Write enable is `RamSelect | sel_d1`, where `sel_d1` is `RamSelect` delayed one cycle.
  - The loader updates `LoadAddr`/`LoadData` on the same edge it samples `RamSelect`.
  - The extra cycle captures the final pair the loader presents after `RamSelect` falls.
- Write: `mem[LoadAddr] <= LoadData` on every edge while write enable is high. Writes to any address are legal and the last write wins.
- The RAM array is not reset; contents survive `Reset`.
- FSM states: IDLE, LOAD, FETCH, PRESENT, HALT.
  - IDLE: `RamSelect` -> LOAD. Otherwise `Start` -> FETCH with `Pc <= 0` and `Halted <= 0`.
  - LOAD: clears `Halted`, forces `Valid` to 0. When `RamSelect` and `sel_d1` are both 0 -> IDLE. `Start` is ignored in this state.
  - FETCH: issues a synchronous read at `Pc`. Next state is PRESENT, with `Instr <= mem[Pc]` and `Valid <= 1`.
  - PRESENT: holds `Instr`, `Valid` and `Pc` stable while `Ready` is 0. On `Valid & Ready`:
    - if `Instr == HALT_WORD` -> HALT, with `Valid <= 0` and `Halted <= 1`;
    - otherwise `Pc <= Pc + 1` (modulo `DEPTH`, so 31 wraps to 0), `Valid <= 0`, next state FETCH.
  - HALT: `Pc` holds the halt word's address. `Start` -> FETCH with `Pc <= 0` and `Halted <= 0`. `RamSelect` -> LOAD.
- `RamSelect` asserted in FETCH or PRESENT aborts the fetch:
  - next state LOAD, with `Valid <= 0` and `Pc <= 0`;
  - an in-flight word is dropped, not delivered.
- `RamSelect` has priority over `Start` in every state.
- `Start` is ignored in FETCH and PRESENT.
- A read and a write never coincide, because fetch states are left as soon as `RamSelect` rises.

## Timing
- Reset values: `Instr=0`, `Valid=0`, `Pc=0`, `Halted=0`, `Busy=0`, state IDLE, `sel_d1=0`.
- `Start` sampled at edge n: FETCH after n, `Valid=1` after edge n+1.
- Minimum 2 cycles per instruction with `Ready` held high. `Valid` is low for exactly 1 cycle between words.
- Halt: `Halted` rises and `Valid` falls on the edge that accepts the halt word.
- Abort: `Valid` is 0 on the edge after `RamSelect` is first sampled high.
- Load latency: a pair presented at edge k is written at edge k (visible to a read issued at k+1).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `ins_pkg`: `ADDR_W`, `DATA_W`, `HALT_WORD`, state enum `fetch_state_t`.
- One sub-module `ins_ram_32x8`:
  - one synchronous write port, one synchronous read port;
  - no reset on the array;
  - parameterised by `ADDR_W`/`DATA_W`.
- Top holds the FSM, `Pc`, `sel_d1` and the output registers.

## Test plan
- Reset asserted mid-PRESENT -> all outputs 0 immediately. After release, `Start` yields the same first word (memory retained).
- Loader sequence, then fetch:
  - stimulus: `RamSelect` high while the loader emits (0,80),(1,3E),(2,80),(3,3F),(4,1E),(5,7F),(6,FF) in hex, then `RamSelect` drops; `Start`, with `Ready=1`;
  - required: `Valid` pulses deliver 80,3E,80,3F,1E,7F,FF; `Halted=1` with `Pc=6`. The pair (6,FF), presented after `RamSelect` falls, must be written.
- Backpressure: `Ready=0` for 3 cycles in PRESENT -> `Instr`, `Valid=1` and `Pc` unchanged. Advance occurs on the first `Ready=1`.
- Wrap: all 32 words = 01, `Start`, `Ready=1` -> after `Pc=31` is accepted, `Pc=0`; `Halted` stays 0.
- Abort: `RamSelect` asserted in PRESENT -> `Valid=0` and `Pc=0` next edge, state LOAD. The dropped word is not counted as consumed.
- Priority: `Start` and `RamSelect` high together in IDLE -> LOAD entered, no fetch, `Busy=0`.
